// File: rtl/threeway_round.sv
// One full 3-Way round: key addition followed by rho = pi_2(gamma(pi_1(theta(.)))) on a 96-bit state.
// Latency 1 cycle (registered output); 0 cycles when THREEWAY_ROUND_COMB_OUT_EN is defined.
// No backpressure: accepts a new input every cycle; odata holds its value while in_valid is low.
module threeway_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [95:0] idata,
    input  logic [95:0] key,
    output logic        out_valid,
    output logic [95:0] odata
);

    // Theta column mix for one word; x is the word itself, y and z its two successors.
    function automatic logic [31:0] theta_word(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic [31:0] z);
        theta_word = x ^ (x >> 16) ^ (y << 16) ^ (y >> 16) ^ (z << 16)
                   ^ (y >> 24) ^ (z << 8) ^ (z >> 8) ^ (x << 24)
                   ^ (z >> 16) ^ (x << 16) ^ (z >> 24) ^ (x << 8);
    endfunction

    logic [31:0] a0, a1, a2;
    logic [31:0] t0, t1, t2;
    logic [31:0] b0, b1, b2;
    logic [31:0] c0, c1, c2;
    logic [95:0] round_dat;

    // Round function: key add, theta, pi_1, gamma, pi_2 as pure combinational logic.
    always_comb begin
        a0 = idata[31:0]  ^ key[31:0];
        a1 = idata[63:32] ^ key[63:32];
        a2 = idata[95:64] ^ key[95:64];

        t0 = theta_word(a0, a1, a2);
        t1 = theta_word(a1, a2, a0);
        t2 = theta_word(a2, a0, a1);

        // pi_1: word 0 rotated right by 10, word 2 rotated left by 1
        b0 = {t0[9:0], t0[31:10]};
        b1 = t1;
        b2 = {t2[30:0], t2[31]};

        // gamma reads only pre-gamma words, so all three are computed in parallel
        c0 = b0 ^ (b1 | ~b2);
        c1 = b1 ^ (b2 | ~b0);
        c2 = b2 ^ (b0 | ~b1);

        // pi_2: word 0 rotated left by 1, word 2 rotated right by 10
        round_dat = {{c2[9:0], c2[31:10]}, c1, {c0[30:0], c0[31]}};
    end

`ifdef THREEWAY_ROUND_COMB_OUT_EN
    // Clock and reset are kept on the port list for drop-in compatibility only.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // Zero-latency variant: outputs follow the inputs directly.
    always_comb begin
        out_valid = in_valid;
        odata     = round_dat;
    end
`else
    logic        out_valid_q, out_valid_d;
    logic [95:0] odata_q, odata_d;

    // Next state: capture a new result only on valid input, otherwise hold.
    always_comb begin
        out_valid_d = in_valid;
        odata_d     = odata_q;
        if (in_valid) begin
            odata_d = round_dat;
        end
    end

    // Output register with synchronous reset taking priority over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            odata_q     <= 96'h0;
        end else begin
            out_valid_q <= out_valid_d;
            odata_q     <= odata_d;
        end
    end

    assign out_valid = out_valid_q;
    assign odata     = odata_q;
`endif

endmodule

// File: tb/tb_threeway_round.sv
module tb_threeway_round;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [95:0] idata;
    logic [95:0] key;
    logic        out_valid;
    logic [95:0] odata;

    int n_chk  = 0;
    int n_pass = 0;

    logic [95:0] exp_q[$];
    logic [95:0] last_exp;

    threeway_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .idata     (idata),
        .key       (key),
        .out_valid (out_valid),
        .odata     (odata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bit-level golden model, written independently of the RTL expression form.
    function automatic logic [31:0] m_rotr(input logic [31:0] w, input int n);
        logic [31:0] r;
        for (int j = 0; j < 32; j++) r[j] = w[(j + n) % 32];
        return r;
    endfunction

    function automatic logic [95:0] model_f(input logic [95:0] d, input logic [95:0] k);
        logic [31:0] a[3];
        logic [31:0] b[3];
        logic [31:0] c[3];
        logic [31:0] x, y, z;
        for (int i = 0; i < 3; i++) a[i] = d[32*i +: 32] ^ k[32*i +: 32];
        for (int i = 0; i < 3; i++) begin
            x = a[i];
            y = a[(i + 1) % 3];
            z = a[(i + 2) % 3];
            b[i] = x ^ (x >> 16) ^ (y << 16) ^ (y >> 16) ^ (z << 16) ^ (y >> 24) ^ (z << 8)
                 ^ (z >> 8) ^ (x << 24) ^ (z >> 16) ^ (x << 16) ^ (z >> 24) ^ (x << 8);
        end
        b[0] = m_rotr(b[0], 10);
        b[2] = m_rotr(b[2], 31);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 32; j++)
                c[i][j] = b[i][j] ^ (b[(i + 1) % 3][j] | ~b[(i + 2) % 3][j]);
        c[0] = m_rotr(c[0], 31);
        c[2] = m_rotr(c[2], 10);
        return {c[2], c[1], c[0]};
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

`ifdef THREEWAY_ROUND_COMB_OUT_EN
    // Apply inputs, then compare 1 time unit later.
    task automatic drive(input logic vld, input logic [95:0] d, input logic [95:0] k, input string tag);
        logic [95:0] e;
        in_valid = vld;
        idata    = d;
        key      = k;
        exp_q.push_back(model_f(d, k));
        #1;
        e = exp_q.pop_front();
        chk({tag, "_vld"}, {95'h0, out_valid}, {95'h0, vld});
        chk(tag, odata, e);
        #9;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 96'h0, 96'h0, "zero");
        drive(1'b1, 96'h0123456789ABCDEF01234567, 96'h0123456789ABCDEF01234567, "cancel");
        drive(1'b0, 96'h0, 96'h0, "novld");
        for (int i = 0; i < 100; i++) drive(1'b1, rnd96(), rnd96(), "rand");
        chk("q_empty", 96'(exp_q.size()), 96'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
`else
    // Inputs change 1 unit after a rising edge and are captured at the next one.
    task automatic drive(input logic vld, input logic [95:0] d, input logic [95:0] k);
        in_valid = vld;
        idata    = d;
        key      = k;
        if (vld) begin
            last_exp = model_f(d, k);
            exp_q.push_back(last_exp);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_vld", odata, 96'hx);
            end else begin
                chk("scoreboard", odata, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        idata    = {96{1'b1}};
        key      = {96{1'b1}};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_odata", odata, 96'h0);
            chk("rst_vld", {95'h0, out_valid}, 96'h0);
        end
        rst = 1'b0;

        drive(1'b1, 96'h0, 96'h0);
        chk("zero_vec", odata, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF);
        drive(1'b1, 96'h0123456789ABCDEF01234567, 96'h0123456789ABCDEF01234567);
        chk("cancel_vec", odata, {96{1'b1}});

        drive(1'b1, 96'hDEADBEEF_CAFEF00D_12345678, 96'h0F1E2D3C_4B5A6978_8796A5B4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, rnd96(), rnd96());
            chk("hold_vld", {95'h0, out_valid}, 96'h0);
            chk("hold_odata", odata, last_exp);
        end

        for (int i = 0; i < 100; i++) drive(1'b1, rnd96(), rnd96());
        drive(1'b0, 96'h0, 96'h0);
        @(negedge clk);
        chk("q_empty", 96'(exp_q.size()), 96'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
